// File: rtl/piso_shift_reg_if.sv
// Load-side handshake and serial output bundle for piso_shift_reg.
// load_valid/load_ready: a word transfers on a rising edge where both are high; parallel_in is only sampled then.
interface piso_shift_reg_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] parallel_in;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_last;
  logic             busy;

  modport master (
    output load_valid, parallel_in,
    input  load_ready, serial_out, serial_valid, serial_last, busy
  );

  modport slave (
    input  load_valid, parallel_in,
    output load_ready, serial_out, serial_valid, serial_last, busy
  );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with back-to-back frame loading.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_shift_reg_if.slave      bus,
  output logic                 state_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FLEN - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_next;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             load_accept;

`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH);
  logic parity_q, parity_d;
`endif

  assign bus.load_ready = rst & ((state_q == ST_IDLE) | last_q);
  assign load_accept    = bus.load_valid & bus.load_ready;
  assign cnt_next       = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (load_accept) begin
      // The first bit leaves straight away; shreg keeps the rest of the word.
      state_d = ST_SHIFT;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        sout_d  = bus.parallel_in[WIDTH-1];
        shreg_d = bus.parallel_in << 1;
      end else begin
        sout_d  = bus.parallel_in[0];
        shreg_d = bus.parallel_in >> 1;
      end
`ifdef PISO_PARITY_EN
      parity_d = ^bus.parallel_in;
`endif
    end else if (state_q == ST_SHIFT) begin
      if (last_q) begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_next;
        last_d = (cnt_next == LAST_IDX);
        if (MSB_FIRST) begin
          sout_d  = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end else begin
          sout_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
`ifdef PISO_PARITY_EN
        if (cnt_next == PAR_IDX) begin
          sout_d = parity_q;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.serial_out   = sout_q;
  assign bus.serial_valid = valid_q;
  assign bus.serial_last  = last_q;
  assign bus.busy         = (state_q == ST_SHIFT);
  assign state_o          = state_q;

endmodule
